mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/ProcTypes.sv | 15 +
 rtl/mem_align.sv | 58 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ProcTypes.sv
// Shared processor types: memory operation codes plus the memory-port arbiter's
// state and grant-owner encodings.
package ProcTypes;

  typedef enum logic [3:0] {NopM, Lw, Lh, Lhu, Lb, Lbu, Sw, Sh, Sb} MemFunc;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} ArbState;

  typedef enum logic {GrantFetch, GrantData} GrantOwner;

  function automatic logic isStore(input MemFunc func);
    return func inside {Sw, Sh, Sb};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory port: store byte enables and replication,
// load byte/half extraction with sign or zero extension, and alignment checking.
module mem_align
  import ProcTypes::*;
(
  input  MemFunc      func,
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadWord,
  output logic        misaligned
);

  logic [15:0] lane;

  // The addressed byte/half is shifted down to bit 0 before extension.
  always_comb begin
    lane       = 16'(readWord >> {offset, 3'b000});
    byteEn     = 4'b0000;
    storeWord  = 32'h0;
    loadWord   = 32'h0;
    misaligned = 1'b0;
    case (func)
      Lw: begin
        loadWord   = readWord;
        misaligned = (offset != 2'b00);
      end
      Lh: begin
        loadWord   = {{16{lane[15]}}, lane};
        misaligned = offset[0];
      end
      Lhu: begin
        loadWord   = {16'h0, lane};
        misaligned = offset[0];
      end
      Lb:  loadWord = {{24{lane[7]}}, lane[7:0]};
      Lbu: loadWord = {24'h0, lane[7:0]};
      Sw: begin
        byteEn     = 4'b1111;
        storeWord  = storeData;
        misaligned = (offset != 2'b00);
      end
      Sh: begin
        byteEn     = 4'b0011 << offset;
        storeWord  = {2{storeData[15:0]}};
        misaligned = offset[0];
      end
      Sb: begin
        byteEn    = 4'b0001 << offset;
        storeWord = {4{storeData[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one single-port memory with a
// fixed read latency; one transaction at a time, alternating grants under contention.
module mem_port_arbiter
  import ProcTypes::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_ready_out,
  output logic        if_rvalid_out,
  output logic [31:0] if_rdata_out,
  input  logic        d_req_in,
  input  MemFunc      d_func_in,
  input  logic [31:0] d_addr_in,
  input  logic [31:0] d_wdata_in,
  output logic        d_ready_out,
  output logic        d_rvalid_out,
  output logic [31:0] d_rdata_out,
  output logic        d_misalign_out,
  output logic        mem_en_out,
  output logic [3:0]  mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [2:0] LatencyCount = 3'(READ_LATENCY);

  ArbState     state;
  GrantOwner   lastGrant;
  GrantOwner   owner;
  MemFunc      savedFunc;
  MemFunc      alignFunc;
  logic [1:0]  savedOffset;
  logic [1:0]  alignOffset;
  logic [2:0]  waitCount;
  logic        isIdle;
  logic        dValid;
  logic        pickData;
  logic        pickFetch;
  logic [31:0] grantAddr;
  logic [3:0]  byteEn;
  logic [31:0] storeWord;
  logic [31:0] loadWord;
  logic        misaligned;
  logic        unusedFetchOffset;

  // Fetch addresses are always treated as word aligned.
  assign unusedFetchOffset = ^if_addr_in[1:0];

  // Data wins unless it was the last one served; the lane logic sees the incoming
  // request while idle and the saved transaction afterwards.
  always_comb begin
    isIdle       = rst_n_in && (state == IDLE);
    dValid       = d_req_in && (d_func_in != NopM);
    pickData     = dValid && (!if_req_in || (lastGrant == GrantFetch));
    pickFetch    = if_req_in && !pickData;
    if_ready_out = isIdle && pickFetch;
    d_ready_out  = isIdle && pickData;
    grantAddr    = pickData ? {d_addr_in[31:2], 2'b00} : {if_addr_in[31:2], 2'b00};
    alignFunc    = savedFunc;
    alignOffset  = savedOffset;
    if (state == IDLE) begin
      alignFunc   = pickData ? d_func_in : Lw;
      alignOffset = pickData ? d_addr_in[1:0] : 2'b00;
    end
  end

  mem_align uAlign (
    .func       (alignFunc),
    .offset     (alignOffset),
    .storeData  (d_wdata_in),
    .readWord   (mem_rdata_in),
    .byteEn     (byteEn),
    .storeWord  (storeWord),
    .loadWord   (loadWord),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      lastGrant      <= GrantFetch;
      owner          <= GrantFetch;
      savedFunc      <= NopM;
      savedOffset    <= 2'b00;
      waitCount      <= 3'd0;
      mem_en_out     <= 1'b0;
      mem_we_out     <= 4'b0000;
      mem_addr_out   <= 32'h0;
      mem_wdata_out  <= 32'h0;
      if_rvalid_out  <= 1'b0;
      if_rdata_out   <= 32'h0;
      d_rvalid_out   <= 1'b0;
      d_rdata_out    <= 32'h0;
      d_misalign_out <= 1'b0;
    end else begin
      if_rvalid_out  <= 1'b0;
      d_rvalid_out   <= 1'b0;
      d_misalign_out <= 1'b0;
      case (state)
        IDLE: begin
          if (if_ready_out || d_ready_out) begin
            lastGrant   <= pickData ? GrantData : GrantFetch;
            owner       <= pickData ? GrantData : GrantFetch;
            savedFunc   <= alignFunc;
            savedOffset <= alignOffset;
            // A misaligned data access answers immediately and never touches memory.
            if (d_ready_out && misaligned) begin
              d_rvalid_out   <= 1'b1;
              d_misalign_out <= 1'b1;
              d_rdata_out    <= 32'h0;
            end else begin
              state         <= ISSUE;
              mem_en_out    <= 1'b1;
              mem_we_out    <= byteEn;
              mem_addr_out  <= grantAddr;
              mem_wdata_out <= storeWord;
            end
          end
        end
        ISSUE: begin
          mem_en_out <= 1'b0;
          mem_we_out <= 4'b0000;
          if (isStore(savedFunc)) begin
            state        <= IDLE;
            d_rvalid_out <= 1'b1;
            d_rdata_out  <= 32'h0;
          end else begin
            state     <= WAIT;
            waitCount <= LatencyCount;
          end
        end
        WAIT: begin
          if (waitCount == 3'd1) begin
            state     <= IDLE;
            waitCount <= 3'd0;
            if (owner == GrantData) begin
              d_rvalid_out <= 1'b1;
              d_rdata_out  <= loadWord;
            end else begin
              if_rvalid_out <= 1'b1;
              if_rdata_out  <= loadWord;
            end
          end else begin
            waitCount <= waitCount - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
